// File: rtl/uart_receiver_param.sv
// uart_receiver_param: parametrised oversampling UART receiver.
// Two-flop input synchroniser, mid-bit start-glitch rejection, framing-error
// detection, valid/ready output register with sticky overrun flag.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined;
// without it, frames are start + DATA_BITS + stop and parity_err is tied to 0.
module uart_receiver_param #(
  parameter int DATA_BITS  = 7,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 rx,
  input  logic                 ready_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic [2:0]           state_out
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SCNT_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(DATA_BITS - 1);

  // Reject unsupported configurations at elaboration.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_receiver_param: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
    $error("uart_receiver_param: OVERSAMPLE must be a power of two >= 4");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_receiver_param: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_s1;
  logic                  r_rx_s;
  logic                  r_armed;
  logic [SW-1:0]         r_scnt;
  logic [BW-1:0]         r_bcnt;
  logic [DATA_BITS-1:0]  r_sh;
  logic [DATA_BITS-1:0]  r_data;
  logic                  r_valid;
  logic                  r_ferr;
  logic                  r_perr;
  logic                  r_overrun;
  logic                  w_bit_end;
  logic                  w_done;

`ifdef UART_RX_PARITY_EN
  logic                  r_p_err;
`endif

  assign w_bit_end = (r_scnt == SCNT_LAST);
  assign w_done    = ena && (r_state == S_STOP) && w_bit_end;

  assign data_out   = r_data;
  assign valid_out  = r_valid;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
  assign overrun    = r_overrun;
  assign state_out  = r_state;

  // Two-flop synchroniser on the asynchronous rx pad, runs every clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_s1   <= rx;
      r_rx_s <= r_s1;
    end
  end

  // Receive FSM (advances on ena) plus the output register and handshake
  // (evaluated every clk). Frame completion takes priority over acceptance,
  // so a same-edge accept+complete leaves valid high without overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_armed   <= 1'b1;
      r_scnt    <= '0;
      r_bcnt    <= '0;
      r_sh      <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
      r_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_p_err   <= 1'b0;
`endif
    end else begin
      if (w_done) begin
        r_data  <= r_sh;
        r_ferr  <= ~r_rx_s;
`ifdef UART_RX_PARITY_EN
        r_perr  <= r_p_err;
`else
        r_perr  <= 1'b0;
`endif
        r_valid <= 1'b1;
        if (r_valid && !ready_in) r_overrun <= 1'b1;
      end else if (r_valid && ready_in) begin
        r_valid <= 1'b0;
      end

      if (ena) begin
        case (r_state)
          S_IDLE: begin
            if (r_rx_s) begin
              r_armed <= 1'b1;
            end else if (r_armed) begin
              r_state <= S_START;
              r_scnt  <= '0;
            end
          end
          S_START: begin
            if (r_scnt == SCNT_MID) begin
              if (r_rx_s) begin
                r_state <= S_IDLE;
              end else begin
                r_state <= S_DATA;
                r_scnt  <= '0;
                r_bcnt  <= '0;
              end
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
          S_DATA: begin
            r_scnt <= r_scnt + 1'b1;
            if (w_bit_end) begin
              r_sh   <= {r_rx_s, r_sh[DATA_BITS-1:1]};
              r_bcnt <= r_bcnt + 1'b1;
              if (r_bcnt == BCNT_LAST) begin
`ifdef UART_RX_PARITY_EN
                r_state <= S_PARITY;
`else
                r_state <= S_STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            r_scnt <= r_scnt + 1'b1;
            if (w_bit_end) begin
              r_p_err <= (^r_sh) ^ r_rx_s ^ 1'(PARITY_ODD);
              r_state <= S_STOP;
            end
          end
`endif
          S_STOP: begin
            r_scnt <= r_scnt + 1'b1;
            if (w_bit_end) begin
              r_state <= S_IDLE;
              // A low stop bit means break/stuck line: wait for high before re-arming.
              if (!r_rx_s) r_armed <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver_param.sv
// tb_uart_receiver_param: directed self-checking bench for uart_receiver_param
// at DATA_BITS=7, OVERSAMPLE=8, PARITY_ODD=0. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_uart_receiver_param;

  localparam int DB = 7;
  localparam int OS = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          rx;
  logic          ready_in;
  logic [DB-1:0] data_out;
  logic          valid_out;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic [2:0]    state_out;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            rise_at;
  logic [2:0]    st_c2, st_c3, st_c7;

  uart_receiver_param #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .rx        (rx),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic accept();
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
  endtask

  // Serialise one frame: start, data LSB first, [even parity ^ pflip], stop.
  // Records the loop index at which valid_out rises and a few state samples.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic pflip);
    logic bits [0:10];
    int   nb;
    logic v0;
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[i+1] = d[i];
    for (int i = DB + 1; i <= 10; i++) bits[i] = 1'b1;
    nb = DB + 2 + PB;
    if (PB == 1) bits[DB+1] = (^d) ^ pflip;
    bits[nb-1] = stop;
    v0 = valid_out;
    rise_at = -1;
    for (int c = 0; c < nb * OS; c++) begin
      if (rise_at < 0 && !v0 && valid_out) rise_at = c;
      if (c == 2) st_c2 = state_out;
      if (c == 3) st_c3 = state_out;
      if (c == 7) st_c7 = state_out;
      rx = bits[c / OS];
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; rx = 1'b1; ready_in = 1'b0;
    idle(3);
    rst = 1'b0;
    check("rst_state", state_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ovr", overrun, 0);
    idle(4);

    // ena low freezes the FSM even with the line low
    ena = 1'b0; rx = 1'b0;
    idle(10);
    check("ena_freeze", state_out, 0);
    rx = 1'b1;
    idle(4);
    ena = 1'b1;
    idle(4);

    // two-clock low glitch: START entered, then rejected at mid-sample
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(1);
    check("glitch_start", state_out, 1);
    idle(10);
    check("glitch_idle", state_out, 0);
    check("glitch_valid", valid_out, 0);
    check("glitch_data", data_out, 0);

    // clean 7'h55 frame with latency and state-timing checks
    send_frame(7'h55, 1'b1, 1'b0);
    check("lat_valid_rise", rise_at, 71 + 8 * PB);
    check("st_e1", st_c2, 0);
    check("st_e2_start", st_c3, 1);
    check("st_e6_data", st_c7, 2);
    check("f55_data", data_out, 7'h55);
    check("f55_valid", valid_out, 1);
    check("f55_ferr", frame_err, 0);
    check("f55_perr", parity_err, 0);
    check("f55_state", state_out, 0);
    accept();
    check("f55_accept", valid_out, 0);
    idle(4);

    // framing error with stop held low for 20 clk: no re-arm while low
    send_frame(7'h2A, 1'b0, 1'b0);
    rx = 1'b0;
    idle(12);
    check("ferr_data", data_out, 7'h2A);
    check("ferr_valid", valid_out, 1);
    check("ferr_flag", frame_err, 1);
    check("ferr_no_rearm", state_out, 0);
    rx = 1'b1;
    idle(4);
    accept();
    check("ferr_accept", valid_out, 0);
    send_frame(7'h4C, 1'b1, 1'b0);
    check("rearm_data", data_out, 7'h4C);
    check("rearm_ferr", frame_err, 0);
    check("rearm_valid", valid_out, 1);
    accept();
    idle(4);

    // back-to-back frames without acceptance -> overrun
    send_frame(7'h11, 1'b1, 1'b0);
    send_frame(7'h22, 1'b1, 1'b0);
    check("ovr_data", data_out, 7'h22);
    check("ovr_valid", valid_out, 1);
    check("ovr_flag", overrun, 1);
    accept();
    check("ovr_accept_valid", valid_out, 0);
    check("ovr_sticky", overrun, 1);
    idle(4);

`ifdef UART_RX_PARITY_EN
    send_frame(7'h03, 1'b1, 1'b0);
    check("par_ok_data", data_out, 7'h03);
    check("par_ok_perr", parity_err, 0);
    check("par_lat", rise_at, 79);
    accept();
    idle(4);
    send_frame(7'h03, 1'b1, 1'b1);
    check("par_bad_perr", parity_err, 1);
    check("par_bad_ferr", frame_err, 0);
    accept();
    idle(4);
`endif

    // reset during DATA bit 3 of a 7'h7F frame
    for (int c = 0; c < 36; c++) begin
      rx = (c < OS) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    check("mid_state_data", state_out, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_state", state_out, 0);
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_ovr", overrun, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_perr", parity_err, 0);
    rx = 1'b1;
    idle(20);
    check("mid_no_pulse", valid_out, 0);
    check("mid_idle", state_out, 0);
    send_frame(7'h7F, 1'b1, 1'b0);
    check("post_rst_data", data_out, 7'h7F);
    check("post_rst_valid", valid_out, 1);
    check("post_rst_ferr", frame_err, 0);
    check("post_rst_perr", parity_err, 0);
    check("post_rst_ovr", overrun, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver_param.md
# uart_receiver_param

Parametrised UART receiver, successor to the fixed 7-bit Hamming receiver. Configurable data width and oversampling ratio, two-flop input synchroniser, mid-bit start-glitch rejection, and framing-error detection. Optional parity checking. Delivers each frame through a valid/ready output register with overrun flagging. Sits between the pad-side `rx` line and the Hamming(7,4) decoder or any wider consumer.

## Interface
- `DATA_BITS`, default 7: data bits per frame, 5–9, LSB first.
- `OVERSAMPLE`, default 8: `ena` ticks per bit; power of two, at least 4.
- `PARITY_ODD`, default 0: 1 selects odd parity, 0 selects even. Used only with `UART_RX_PARITY_EN`.
- `clk` input 1: clock.
- `rst` input 1: reset. **Synchronous, active-high.**
- `ena` input 1: oversample tick. Receive logic advances only on clk edges with `ena`=1.
- `rx` input 1: asynchronous serial line, idle high.
- `ready_in` input 1: consumer accepts `data_out` when high together with `valid_out`.
- `data_out` output DATA_BITS: last received frame's data.
- `valid_out` output 1: `data_out`, `frame_err` and `parity_err` hold an unconsumed frame.
- `frame_err` output 1: stop bit of the held frame sampled low.
- `parity_err` output 1: parity mismatch on the held frame. Constant 0 without the macro.
- `overrun` output 1: sticky; a frame arrived while the previous one was still unconsumed.
- `state_out` output 3: current FSM state.

## Operation
- Synchroniser: `rx` → `s1` → `rx_s` on every clk, independent of `ena`. All decisions use `rx_s`.
- Counters:
  - `scnt` is $clog2(OVERSAMPLE) bits and wraps at OVERSAMPLE-1.
  - `bcnt` is $clog2(DATA_BITS+1) bits.
  - The shift register is DATA_BITS wide and shifts right, `{rx_s, sh[DATA_BITS-1:1]}`.
- State encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4. Other codes return to IDLE.
- IDLE:
  - If `armed`=1 and `rx_s`=0 → START with `scnt`=0.
  - If `rx_s`=1 → `armed`=1.
- START:
  - Increment `scnt` each tick.
  - At `scnt`=OVERSAMPLE/2-1: if `rx_s`=1, treat it as a glitch and go to IDLE with no output change. Otherwise go to DATA with `scnt`=0 and `bcnt`=0.
- DATA:
  - At `scnt`=OVERSAMPLE-1: shift `rx_s` in and increment `bcnt`.
  - After the DATA_BITS-th sample → PARITY if enabled, else STOP.
- PARITY:
  - At `scnt`=OVERSAMPLE-1: capture `p_err` = (XOR of shift register ^ `rx_s` ^ PARITY_ODD) ≠ 0.
  - Then → STOP.
- STOP, at `scnt`=OVERSAMPLE-1:
  - Load `data_out`←shift register, `frame_err`←~`rx_s`, `parity_err`←`p_err`.
  - Set `valid_out`=1.
  - Go to IDLE.
  - If `rx_s`=0, set `armed`=0, so a break or stuck-low line is not re-detected until the line returns high.
- Handshake, evaluated every clk regardless of `ena`:
  - `valid_out && ready_in` clears `valid_out` unless a frame completes on the same edge.
  - Frame completes while `valid_out`=1 and `ready_in`=0: overwrite outputs, keep `valid_out`=1, set `overrun`=1.
  - Completion and acceptance on the same edge: new frame loaded, `valid_out` stays 1, no overrun.
- `overrun` clears only on `rst`.
- `ena`=0 freezes the FSM and all counters. The synchroniser and handshake continue.
- Reset values:
  - State IDLE, `armed`=1, counters 0, synchroniser flops 1.
  - `data_out`=0, `valid_out`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `state_out`=0.
- Reset mid-frame abandons the frame, with no output pulse. Reception resumes on the next falling edge after reset.

## Timing
- All outputs are registered. `state_out` equals the state register.
- Synchroniser latency is 2 clk.
- With `ena`=1 every clk, DATA_BITS=7 and OVERSAMPLE=8:
  - Let e0 be the first edge at which `rx` is low.
  - IDLE→START on e2; START→DATA on e6.
  - Bit k sampled on e14+8k.
  - Without parity: STOP sample on e70, so `valid_out`=1 after e70.
  - With parity: `valid_out`=1 after e78.
- General frame latency is 2 + 1 + OVERSAMPLE/2 + OVERSAMPLE·(DATA_BITS + P + 1) clk-enabled edges, where P=1 with parity and 0 without.
- Minimum glitch rejected: any low pulse that is not still low at the START mid-sample.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is present and frames carry one parity bit before the stop bit.
  - `parity_err` is driven as in Operation.
- Not defined:
  - STOP directly follows DATA and PARITY is unreachable.
  - `parity_err` is tied to 0.
  - Frame is start + DATA_BITS + stop.

## Test plan
- Defaults, `ena`=1, `ready_in`=0, frame data 7'h55 with stop=1 → `data_out`=7'h55, `valid_out`=1 after e70, `frame_err`=0, `state_out` back to 0.
- `rx` low for 2 clk then high (glitch) → START entered and then IDLE, `valid_out` stays 0, `data_out` stays 0.
- Frame 7'h2A with stop bit 0 held low for 20 clk, then high → `valid_out`=1, `frame_err`=1. No second frame until `rx` has gone high and then falls again.
- Two back-to-back frames 7'h11 then 7'h22, `ready_in`=0 → `data_out`=7'h22, `overrun`=1. Then `ready_in`=1 for one clk → `valid_out`=0 and `overrun` stays 1.
- `UART_RX_PARITY_EN`, PARITY_ODD=0:
  - Frame 7'h03 with parity bit 0 → `parity_err`=0.
  - Same frame with parity bit 1 → `parity_err`=1.
  - `valid_out` rises after e78.
- `rst`=1 for one clk during DATA bit 3 → all outputs 0 and state IDLE on the next edge. A following clean 7'h7F frame is received correctly.
